rom_bus_arb: RTL and testbench

- Two-requester arbiter and access sequencer for the shared asynchronous program ROM bus (16-bit address, 8-bit tri-state data, active-low output enable).
- Requester 0 is the 6502 core fetch port; requester 1 is the DMA/loader port.
- Latches the winning address, then sequences setup, enable and turnaround phases with programmable wait states.
- Returns captured read data with a one-cycle acknowledge pulse.

---
 rtl/rom_bus_arb.sv | 125 ++++++++++++
 tb/tb_rom_bus_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arb.sv
// rom_bus_arb: two-port arbiter and access sequencer for the shared
// asynchronous program ROM bus. Port 0 is the 6502 fetch port, port 1 the
// DMA/loader port. Each access runs IDLE -> SETUP -> ACCESS -> RECOVER with
// WAIT_CYCLES cycles of output enable, then pulses the owner's ack.
// Optional feature: define ROM_BUS_ARB_RR_EN for round-robin priority;
// the default build uses fixed priority with port 0 winning.
module rom_bus_arb #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 16,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] bus_addr,
    input  logic [DW-1:0] bus_data,
    output logic          bus_oe_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RECOVER
    } state_t;

    // The counter counts down to zero, so it is loaded with one less than
    // the number of enable cycles wanted.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       owner;
    logic       winner;

`ifdef ROM_BUS_ARB_RR_EN
    logic rr_ptr;

    // Pick the preferred port on contention, otherwise the lone requester
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = rr_ptr;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // Hand preference to the other port whenever an access completes
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (state == ACCESS && wait_cnt == 4'd0) begin
            rr_ptr <= ~owner;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not asking
    always_comb begin
        winner = ~req0;
    end
`endif

    // Access sequencer with every bus and handshake output registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bus_oe_n <= 1'b1;
            bus_addr <= '0;
            rdata    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            wait_cnt <= 4'd0;
            owner    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus_oe_n <= 1'b1;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    if (req0 || req1) begin
                        bus_addr <= winner ? addr1 : addr0;
                        owner    <= winner;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= WAIT_LOAD;
                    bus_oe_n <= 1'b0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rdata    <= bus_data;
                        ack0     <= ~owner;
                        ack1     <= owner;
                        bus_oe_n <= 1'b1;
                        state    <= RECOVER;
                    end
                end
                RECOVER: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bus_arb.sv
// tb_rom_bus_arb: self-checking bench for rom_bus_arb. A behavioural ROM
// answers on the bus, a scoreboard holds the expected {port, addr, data}
// of every access, and extra instances cover WAIT_CYCLES of 1 and 15.
module tb_rom_bus_arb;

    localparam int TB_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic        ack0, ack1;
    logic [7:0]  rdata;
    logic        busy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_oe_n;

    logic        w_req   [2];
    logic [15:0] w_addr  [2];
    logic        w_ack0  [2];
    logic        w_ack1  [2];
    logic [7:0]  w_rdata [2];
    logic        w_busy  [2];
    logic [15:0] w_baddr [2];
    logic [7:0]  w_bdata [2];
    logic        w_oen   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int oe_low = 0;

    typedef struct packed {
        logic        port;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb_q[$];
    logic ptr_model = 1'b0;

    typedef struct {
        bit          r0;
        bit          r1;
        logic [15:0] a0;
        logic [15:0] a1;
        int          n;
        bit          hold;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    // ROM contents; location 5 holds the LDA immediate opcode
    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [15:0] t;
        if (a == 16'h0005) return 8'hA9;
        t = a * 16'd37 + 16'd11;
        return t[7:0] ^ t[15:8];
    endfunction

    assign bus_data   = bus_oe_n ? 8'hEE : rom_fn(bus_addr);
    assign w_bdata[0] = w_oen[0] ? 8'hEE : rom_fn(w_baddr[0]);
    assign w_bdata[1] = w_oen[1] ? 8'hEE : rom_fn(w_baddr[1]);

    rom_bus_arb #(.WAIT_CYCLES(TB_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_oe_n(bus_oe_n)
    );

    rom_bus_arb #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset),
        .req0(w_req[0]), .addr0(w_addr[0]), .req1(1'b0), .addr1(16'h0000),
        .ack0(w_ack0[0]), .ack1(w_ack1[0]), .rdata(w_rdata[0]), .busy(w_busy[0]),
        .bus_addr(w_baddr[0]), .bus_data(w_bdata[0]), .bus_oe_n(w_oen[0])
    );

    rom_bus_arb #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset(reset),
        .req0(w_req[1]), .addr0(w_addr[1]), .req1(1'b0), .addr1(16'h0000),
        .ack0(w_ack0[1]), .ack1(w_ack1[1]), .rdata(w_rdata[1]), .busy(w_busy[1]),
        .bus_addr(w_baddr[1]), .bus_data(w_bdata[1]), .bus_oe_n(w_oen[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic pushExpected(input logic p, input logic [15:0] a);
        exp_t e;
        e.port = p;
        e.addr = a;
        e.data = rom_fn(a);
        sb_q.push_back(e);
        ptr_model = ~p;
    endtask

    // Scoreboard pop on every ack, plus output-enable width tracking
    always @(negedge clk) begin
        exp_t e;
        if (ack0 || ack1) begin
            checkOutput("one_hot_ack", 32'(ack0 & ack1), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack actual=%0b%0b expected=00 at cycle %0d", ack0, ack1, cyc);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ack_port", 32'(ack1), 32'(e.port));
                checkOutput("rdata", 32'(rdata), 32'(e.data));
                checkOutput("bus_addr", 32'(bus_addr), 32'(e.addr));
            end
        end
        if (reset) begin
            oe_low = 0;
        end else if (!bus_oe_n) begin
            oe_low++;
        end else if (oe_low > 0) begin
            checkOutput("oe_width", oe_low, TB_WAIT);
            oe_low = 0;
        end
    end

    task automatic applyStimulus(input vec_t v, output int s);
        logic first;
        @(negedge clk);
        req0  = v.r0;
        req1  = v.r1;
        addr0 = v.a0;
        addr1 = v.a1;
        s     = cyc;
        if (v.r0 && v.r1) begin
`ifdef ROM_BUS_ARB_RR_EN
            first = ptr_model;
`else
            first = 1'b0;
`endif
            pushExpected(first, first ? v.a1 : v.a0);
            pushExpected(~first, first ? v.a0 : v.a1);
        end else begin
            for (int k = 0; k < v.n; k++) begin
                pushExpected(v.r1, v.r1 ? v.a1 : v.a0);
            end
        end
    endtask

    task automatic waitAcks(input int n, input bit hold, input int s);
        int seen = 0;
        int budget = 0;
        int last = 0;
        int busy_low = 0;
        while (seen < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (seen > 0 && !busy) busy_low++;
            if (ack0 || ack1) begin
                if (seen == 0) checkOutput("latency", cyc - s, TB_WAIT + 2);
                else checkOutput("ack_spacing", cyc - last, TB_WAIT + 3);
                last = cyc;
                seen++;
                if (ack0) req0 = 1'b0;
                if (ack1 && (!hold || seen == n)) req1 = 1'b0;
            end
        end
        checkOutput("ack_count", seen, n);
        if (n > 1) checkOutput("busy_gap", busy_low, n - 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic latencyTest(input int idx, input int w);
        int c = 0;
        int low = 0;
        bit got = 0;
        @(negedge clk);
        w_req[idx]  = 1'b1;
        w_addr[idx] = 16'h0005;
        while (!got && c < 40) begin
            @(negedge clk);
            c++;
            if (!w_oen[idx]) low++;
            if (w_ack0[idx]) begin
                got = 1;
                w_req[idx] = 1'b0;
                checkOutput("w_rdata", 32'(w_rdata[idx]), 32'h0A9);
                checkOutput("w_ack1", 32'(w_ack1[idx]), 32'd0);
                checkOutput("w_busy", 32'(w_busy[idx]), 32'd1);
            end
        end
        checkOutput(w == 1 ? "w1_latency" : "w15_latency", c, w + 2);
        checkOutput(w == 1 ? "w1_oe_width" : "w15_oe_width", low, w);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int b;
        int aborted;

        tbl[0] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h0003, 16'h0007, 2, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 3, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 16'h0003, 16'h0007, 2, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h8000, 16'h00FF, 2, 1'b0};

        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 16'h0000;
        addr1 = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            w_req[i]  = 1'b0;
            w_addr[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_oe_n", 32'(bus_oe_n), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        checkOutput("reset_bus_addr", 32'(bus_addr), 32'd0);
        checkOutput("reset_acks", 32'({ack0, ack1}), 32'd0);

        latencyTest(0, 1);
        latencyTest(1, 15);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i], s);
            waitAcks(tbl[i].n, tbl[i].hold, s);
        end

        // Address moved while the access is in flight must be ignored
        applyStimulus('{1'b1, 1'b0, 16'h0002, 16'h0000, 1, 1'b0}, s);
        b = 0;
        while (bus_oe_n && b < 20) begin
            @(negedge clk);
            b++;
        end
        checkOutput("oe_assert", 32'(b < 20), 32'd1);
        addr0 = 16'h0009;
        waitAcks(1, 1'b0, s);

        // Reset in the middle of ACCESS aborts without an ack
        @(negedge clk);
        req0  = 1'b1;
        addr0 = 16'h0004;
        b = 0;
        while (bus_oe_n && b < 20) begin
            @(negedge clk);
            b++;
        end
        checkOutput("abort_oe_assert", 32'(b < 20), 32'd1);
        reset = 1'b1;
        req0  = 1'b0;
        @(negedge clk);
        checkOutput("abort_oe_n", 32'(bus_oe_n), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ptr_model = 1'b0;
        aborted = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack0 || ack1) aborted++;
        end
        checkOutput("abort_no_ack", aborted, 0);
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
